data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Responder end of the pipeline's data-memory interface: serves the mem_read/mem_write requests the control unit raises for Load and Store.
- Holds a word-organised data RAM and performs byte, half and word access with sign or zero extension.
- Inserts a configurable number of wait states and returns one response pulse per request.
- Sits beside the MEM stage; the pipeline stalls while req_ready is low.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM; power of two, at least 2.
- WAIT_CYCLES, 2, extra latency cycles inserted per access; range 0 to 15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present; sampled only while req_ready=1.
- mem_read  in  1  load request from the control unit.
- mem_write  in  1  store request from the control unit; takes precedence over mem_read.
- funct3  in  3  access width and signedness (RV32I load/store encoding).
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2); the low bytes are used.
- req_ready  out  1  high only in IDLE.
- rsp_valid  out  1  one-cycle response pulse.
- rdata  out  32  extended load data; valid while rsp_valid=1.
- misaligned  out  1  error flag qualified by rsp_valid.

Behaviour:
- Reset values: FSM=IDLE, req_ready=1, rsp_valid=0, rdata=0, misaligned=0, wait counter=0. RAM contents are not reset.
- Accept condition: req_valid & req_ready & (mem_read | mem_write). A request with neither mem_read nor mem_write set is ignored and the FSM stays in IDLE.
- Access type: mem_write=1 means store, regardless of mem_read (Store asserts both). Otherwise mem_read=1 means load.
- On accept, register addr, wdata, funct3 and the access type.
- FSM states:
  - IDLE: on accept, go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else go to RESP. A misaligned request always goes straight to RESP.
  - WAIT: counter decrements each cycle; at 0, go to RESP.
  - RESP: rsp_valid=1 for exactly this cycle; the store write happens on this edge; return to IDLE. req_ready=0 in this state, so back-to-back accepts are spaced by at least one IDLE cycle.
- Latency: a request accepted at cycle T produces rsp_valid at T+1+WAIT_CYCLES. A misaligned request responds at T+1.
- Word index: addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- Loads:
  - funct3 000 = LB (sign-extended), 001 = LH (sign-extended), 010 = LW, 100 = LBU (zero-extended), 101 = LHU (zero-extended).
  - The byte or half is selected by addr[1:0] / addr[1].
  - Any other funct3 returns rdata=0 with misaligned=0.
- Stores:
  - funct3 000 = SB, 001 = SH, 010 = SW. The byte lanes written are selected by addr[1:0].
  - Unwritten lanes keep their old value.
  - Any other funct3 writes nothing. A store response has rdata=0.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0. The response carries misaligned=1 and rdata=0, the RAM is not modified, and no wait states are inserted.
- rdata and misaligned hold their value until the next response; they are only meaningful while rsp_valid=1.
- Reset asserted mid-operation: the FSM returns to IDLE at once, a pending store is dropped (RAM untouched), and no response is issued.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_TRAP_EN.
- Defined: misalignment detection as described under Behaviour.
- Undefined: misaligned is tied to 0. The address bits below the access size are forced to 0 (addr[0] for half, addr[1:0] for word), the access proceeds as aligned, and the normal wait states apply.

Decomposition:
- defines.v (shared) gets the funct3 width constants LB/LH/LW/LBU/LHU/SB/SH/SW, the DATA_MEM FSM state encodings, and the default wait-count constant.
- One natural combinational sub-module, mem_load_align. Inputs: raw word, addr[1:0], funct3. Outputs: the extended load data and the byte-lane write mask with the shifted write data.
- The FSM and RAM stay in data_mem_responder.

Test Plan:
- SW then LW, WAIT_CYCLES=2: SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 → each rsp_valid arrives exactly 3 cycles after accept; load rdata=0xDEADBEEF; req_ready=0 throughout.
- Byte/half extension: word at 0x20 = 0x80FF7F01. LB 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080; LH 0x22 → 0xFFFF80FF; LHU 0x20 → 0x00007F01.
- SB wdata=0x000000AA at 0x21 over word 0x11223344, then LW 0x20 → 0x1122AA44.
- Misalignment with the macro defined: LW 0x22 → rsp_valid at T+1, misaligned=1, rdata=0. SW 0x21 → misaligned=1, and a following LW 0x20 shows the RAM unchanged.
- Wrap and ignore, DEPTH_WORDS=256: SW 0x400 wdata=5, then LW 0x000 → 5. A req_valid with mem_read=0 and mem_write=0 → no response, FSM stays IDLE.
- Reset mid-access: SW accepted, rst_n pulsed low during WAIT → no rsp_valid, req_ready=1 after reset, and LW of that address returns the prior value.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder: funct3 encodings,
// FSM states, access-size decode and the captured request payload.
package data_mem_responder_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned F3_W                = 3;
  localparam int unsigned WAIT_W              = 4;
  localparam int unsigned NUM_LANES           = XLEN / 8;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;
  localparam logic [F3_W-1:0] F3_SB  = 3'b000;
  localparam logic [F3_W-1:0] F3_SH  = 3'b001;
  localparam logic [F3_W-1:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } acc_size_e;

  // Request as held between accept and response.
  typedef struct packed {
    logic            store;
    logic            mis;
    logic [F3_W-1:0] funct3;
    logic [1:0]      byte_off;
    logic [XLEN-1:0] wdata;
  } dm_req_t;

  // Loads and stores share funct3 codes but differ in which codes are legal.
  function automatic acc_size_e access_size(input logic store, input logic [F3_W-1:0] f3);
    acc_size_e sz;
    sz = SZ_NONE;
    if (store) begin
      case (f3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        F3_SW:   sz = SZ_WORD;
        default: sz = SZ_NONE;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        F3_LW:         sz = SZ_WORD;
        default:       sz = SZ_NONE;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] off);
    return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
  endfunction

  function automatic logic [1:0] align_offset(input acc_size_e sz, input logic [1:0] off);
    logic [1:0] res;
    case (sz)
      SZ_HALF: res = {off[1], 1'b0};
      SZ_WORD: res = 2'b00;
      default: res = off;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Lane steering between a RAM word and the core: extends load data and builds
// the byte-lane write mask with lane-shifted store data.
module mem_load_align
  import data_mem_responder_pkg::*;
(
  input  logic [XLEN-1:0]      raw_word,
  input  logic [1:0]           byte_off,
  input  logic [F3_W-1:0]      funct3,
  input  logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      load_data_c,
  output logic [NUM_LANES-1:0] wmask_c,
  output logic [XLEN-1:0]      wdata_shifted_c
);

  logic [4:0]  sh_amt;
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  assign sh_amt          = {byte_off, 3'b000};
  assign half_lane       = 16'(raw_word >> sh_amt);
  assign byte_lane       = half_lane[7:0];
  assign wdata_shifted_c = wdata << sh_amt;

  always_comb begin : load_extend
    load_data_c = '0;
    case (funct3)
      F3_LB:   load_data_c = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   load_data_c = {{16{half_lane[15]}}, half_lane};
      F3_LW:   load_data_c = raw_word;
      F3_LBU:  load_data_c = {24'h0, byte_lane};
      F3_LHU:  load_data_c = {16'h0, half_lane};
      default: load_data_c = '0;
    endcase
  end

  always_comb begin : store_lanes
    wmask_c = '0;
    case (funct3)
      F3_SB:   wmask_c = 4'(4'b0001 << byte_off);
      F3_SH:   wmask_c = 4'(4'b0011 << byte_off);
      F3_SW:   wmask_c = 4'b1111;
      default: wmask_c = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte/half/word access and WAIT_CYCLES wait states.
// Define DATA_MEM_MISALIGN_TRAP_EN to report misaligned accesses instead of aligning them.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [F3_W-1:0] funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rdata,
  output logic            misaligned
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

  logic [XLEN-1:0] ram [DEPTH_WORDS];

  dm_state_e         state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  dm_req_t           req_q, in_req, eff_req;
  logic [IDX_W-1:0]  idx_q, eff_idx;
  logic              accept, in_idle, in_mis, capture, ram_we;
  logic              ready_d, rsp_d, mis_d;
  logic [XLEN-1:0]   rdata_d, raw_word;
  logic [1:0]        in_off;
  acc_size_e         in_size;

  logic [XLEN-1:0]      load_data_c, wdata_shifted_c;
  logic [NUM_LANES-1:0] wmask_c;

  // Address bits above the RAM size wrap and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[XLEN-1:IDX_W+2];

  assign in_size = access_size(mem_write, funct3);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign in_mis  = is_misaligned(in_size, addr[1:0]);
  assign in_off  = addr[1:0];
`else
  assign in_mis  = 1'b0;
  assign in_off  = align_offset(in_size, addr[1:0]);
`endif

  assign accept  = req_valid & req_ready & (mem_read | mem_write);
  assign in_idle = (state_q == ST_IDLE);

  assign in_req = '{store: mem_write, mis: in_mis, funct3: funct3, byte_off: in_off, wdata: wdata};

  // In IDLE the live request feeds the datapath so a zero-wait access can respond next cycle.
  assign eff_req  = in_idle ? in_req : req_q;
  assign eff_idx  = in_idle ? addr[IDX_W+1:2] : idx_q;
  assign raw_word = ram[eff_idx];

  mem_load_align u_align (
    .raw_word        (raw_word),
    .byte_off        (eff_req.byte_off),
    .funct3          (eff_req.funct3),
    .wdata           (eff_req.wdata),
    .load_data_c     (load_data_c),
    .wmask_c         (wmask_c),
    .wdata_shifted_c (wdata_shifted_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin : next_state_logic
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (in_mis || (WAIT_CYCLES == 0)) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : output_logic
    cnt_d   = cnt_q;
    ready_d = (state_d == ST_IDLE);
    rsp_d   = (state_d == ST_RESP);
    rdata_d = rdata;
    mis_d   = misaligned;
    capture = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        capture = accept;
        if (state_d == ST_WAIT) cnt_d = WAIT_LOAD;
      end
      ST_WAIT: if (cnt_q != '0) cnt_d = cnt_q - WAIT_W'(1);
      ST_RESP: ram_we = req_q.store & ~req_q.mis;
      default: ;
    endcase
    // Response data is latched on the edge that enters RESP.
    if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
      rdata_d = (eff_req.store || eff_req.mis) ? '0 : load_data_c;
      mis_d   = eff_req.mis;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : out_regs
    if (!rst_n) begin
      cnt_q      <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
      req_q      <= '0;
      idx_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      req_ready  <= ready_d;
      rsp_valid  <= rsp_d;
      rdata      <= rdata_d;
      misaligned <= mis_d;
      if (capture) begin
        req_q <= in_req;
        idx_q <= addr[IDX_W+1:2];
      end
    end
  end

  // RAM contents are not reset; stores commit on the edge leaving RESP.
  always_ff @(posedge clk) begin : ram_write
    if (ram_we) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (wmask_c[i]) ram[idx_q][8*i +: 8] <= wdata_shifted_c[8*i +: 8];
      end
    end
  end

endmodule
